// File: rtl/updown_counter.sv
// Modulo-MOD_VALUE up/down counter with load, wrap/saturate boundary, cascade tc and sticky ovf.
// Optional step prescaler is compiled in with `define UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter #(
  parameter int unsigned N_BITS       = 4,
  parameter int unsigned MOD_VALUE    = 2**N_BITS,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic              clk,
  input  logic              asyn_rst,
  input  logic              en,
  input  logic              up_dn,
  input  logic              load,
  input  logic [N_BITS-1:0] load_value,
  input  logic              sat_mode,
  input  logic              clr_ovf,
  output logic [N_BITS-1:0] count,
  output logic              tc,
  output logic              ovf
);

  localparam logic [N_BITS-1:0] MaxVal = N_BITS'(MOD_VALUE - 1);

  if ((MOD_VALUE < 2) || (MOD_VALUE > 2**N_BITS)) begin : g_bad_mod
    $error("updown_counter: MOD_VALUE must be in 2..2**N_BITS");
  end

  logic [N_BITS-1:0] r_count;
  logic [N_BITS-1:0] w_count_d;
  logic              r_ovf;
  logic              w_ovf_d;
  logic              w_step_q;
  logic              w_step;
  logic              w_at_max;
  logic              w_at_min;
  logic              w_boundary;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  if (PRESCALE_DIV < 2) begin : g_bad_div
    $error("updown_counter: PRESCALE_DIV must be >= 2");
  end

  localparam int unsigned  PreW   = $clog2(PRESCALE_DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE_DIV - 1);

  logic [PreW-1:0] r_pre;
  logic [PreW-1:0] w_pre_d;

  always_comb begin
    w_pre_d = r_pre;
    if (load) begin
      w_pre_d = '0;
    end else if (en) begin
      w_pre_d = (r_pre == PreMax) ? '0 : r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_pre_d;
    end
  end

  assign w_step_q = (r_pre == PreMax);
`else
  // PRESCALE_DIV has no effect in this build.
  if (PRESCALE_DIV == 0) begin : g_div_unused
  end

  assign w_step_q = 1'b1;
`endif

  assign w_at_max   = (r_count == MaxVal);
  assign w_at_min   = (r_count == '0);
  assign w_boundary = up_dn ? w_at_max : w_at_min;
  assign w_step     = en & ~load & w_step_q;
  assign tc         = w_step & w_boundary;

  always_comb begin
    w_count_d = r_count;
    if (load) begin
      w_count_d = (load_value > MaxVal) ? MaxVal : load_value;
    end else if (w_step) begin
      if (up_dn) begin
        w_count_d = w_at_max ? (sat_mode ? MaxVal : '0) : r_count + 1'b1;
      end else begin
        w_count_d = w_at_min ? (sat_mode ? '0 : MaxVal) : r_count - 1'b1;
      end
    end
  end

  // Set beats a coincident clear so no boundary event is lost.
  assign w_ovf_d = tc ? 1'b1 : (clr_ovf ? 1'b0 : r_ovf);

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter (N_BITS=4, MOD_VALUE=10, PRESCALE_DIV=4).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_updown_counter;

  logic       clk;
  logic       asyn_rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_value;
  logic       sat_mode;
  logic       clr_ovf;
  logic [3:0] count;
  logic       tc;
  logic       ovf;

  updown_counter #(
    .N_BITS      (4),
    .MOD_VALUE   (10),
    .PRESCALE_DIV(4)
  ) dut (
    .clk       (clk),
    .asyn_rst  (asyn_rst),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_value(load_value),
    .sat_mode  (sat_mode),
    .clr_ovf   (clr_ovf),
    .count     (count),
    .tc        (tc),
    .ovf       (ovf)
  );

  typedef struct {
    string      nm;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  exp_t p_e;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are presented for checking at every falling edge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      m_e = sb_q.pop_front();
      n_cmp = n_cmp + 3;
      if (count !== m_e.cnt) begin
        n_err++;
        $display("FAIL %s count: got %0d expected %0d", m_e.nm, count, m_e.cnt);
      end
      if (tc !== m_e.tc) begin
        n_err++;
        $display("FAIL %s tc: got %b expected %b", m_e.nm, tc, m_e.tc);
      end
      if (ovf !== m_e.ovf) begin
        n_err++;
        $display("FAIL %s ovf: got %b expected %b", m_e.nm, ovf, m_e.ovf);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [3:0] e_cnt, input logic e_tc,
                          input logic e_ovf);
    p_e.nm  = nm;
    p_e.cnt = e_cnt;
    p_e.tc  = e_tc;
    p_e.ovf = e_ovf;
    sb_q.push_back(p_e);
  endtask

  // One cycle: drive after the rising edge; expectation is what the next falling edge shows.
  task automatic cyc(input string nm, input logic t_en, input logic t_up, input logic t_ld,
                     input logic [3:0] t_lv, input logic t_sat, input logic t_clr,
                     input logic chk, input logic [3:0] e_cnt, input logic e_tc,
                     input logic e_ovf);
    @(posedge clk);
    #1;
    en         = t_en;
    up_dn      = t_up;
    load       = t_ld;
    load_value = t_lv;
    sat_mode   = t_sat;
    clr_ovf    = t_clr;
    if (chk) push_exp(nm, e_cnt, e_tc, e_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    asyn_rst   = 1'b1;
    en         = 1'b0;
    up_dn      = 1'b0;
    load       = 1'b0;
    load_value = 4'd0;
    sat_mode   = 1'b0;
    clr_ovf    = 1'b0;
    repeat (2) @(posedge clk);
    cyc("reset", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    #1 asyn_rst = 1'b0;

`ifndef UPDOWN_COUNTER_PRESCALE_EN
    // Wrap up
    for (int i = 0; i < 12; i++) begin
      cyc($sformatf("wrap_up%0d", i), 1, 1, 0, 0, 0, 0, 1, 4'(i % 10), (i % 10) == 9, i >= 10);
    end
    cyc("hold",        0, 1, 0, 0, 0, 0, 1, 2, 0, 1);
    // Wrap down, then saturate down
    cyc("ld0",         0, 0, 1, 0, 0, 0, 1, 2, 0, 1);
    cyc("wrap_dn_tc",  1, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    cyc("wrap_dn_cnt", 0, 0, 1, 0, 1, 1, 1, 9, 0, 1);
    cyc("sat_dn0",     1, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    cyc("sat_dn1",     1, 0, 0, 0, 1, 0, 1, 0, 1, 1);
    cyc("sat_dn2",     1, 0, 0, 0, 1, 0, 1, 0, 1, 1);
    cyc("sat_hold",    0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    // Load priority and clamp
    cyc("ld_pri",      1, 1, 1, 4, 0, 0, 1, 0, 0, 1);
    cyc("ld_clamp",    1, 1, 1, 13, 0, 0, 1, 4, 0, 1);
    cyc("clamp_val",   0, 1, 0, 0, 0, 0, 1, 9, 0, 1);
    cyc("clr",         0, 1, 0, 0, 0, 1, 1, 9, 0, 1);
    cyc("ld_no_ovf",   0, 1, 1, 13, 0, 0, 1, 9, 0, 0);
    cyc("ld_no_ovf2",  0, 1, 0, 0, 0, 0, 1, 9, 0, 0);
    // ovf set/clear race
    cyc("race",        1, 1, 0, 0, 0, 1, 1, 9, 1, 0);
    cyc("race_set",    0, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    cyc("race_clr",    0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    // Async reset mid-count
    cyc("dn_wrap",     1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc("ld6",         0, 1, 1, 6, 0, 0, 1, 9, 0, 1);
    cyc("at6",         0, 1, 0, 0, 0, 0, 1, 6, 0, 1);
    @(posedge clk);
    #1;
    en    = 1'b1;
    up_dn = 1'b1;
    load  = 1'b0;
    push_exp("async_rst", 0, 0, 0);
    #2 asyn_rst = 1'b1;
    @(posedge clk);
    #1;
    asyn_rst = 1'b0;
    push_exp("rst_release", 0, 0, 0);
    cyc("after_rst",   0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
`endif

    // Prescaler: 8 enabled cycles from 0, then a load mid-period
    cyc("pre_ld",      0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
`ifdef UPDOWN_COUNTER_PRESCALE_EN
      cyc($sformatf("pre%0d", i), 1, 1, 0, 0, 0, 0, 1, 4'(i / 4), 0, 0);
`else
      cyc($sformatf("pre%0d", i), 1, 1, 0, 0, 0, 0, 1, 4'(i), 0, 0);
`endif
    end
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    cyc("pre_tot",     0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
    cyc("mid_ld0",     0, 1, 1, 0, 0, 0, 1, 2, 0, 0);
    cyc("mid_a",       1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("mid_b",       1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("mid_ld5",     1, 1, 1, 5, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("mid_run%0d", i), 1, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    end
    cyc("mid_end",     0, 1, 0, 0, 0, 0, 1, 6, 0, 0);
`else
    cyc("pre_tot",     0, 1, 0, 0, 0, 0, 1, 8, 0, 0);
    cyc("mid_ld0",     0, 1, 1, 0, 0, 0, 1, 8, 0, 0);
    cyc("mid_a",       1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("mid_b",       1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc("mid_ld5",     1, 1, 1, 5, 0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("mid_run%0d", i), 1, 1, 0, 0, 0, 0, 1, 4'(5 + i), 0, 0);
    end
    cyc("mid_end",     0, 1, 0, 0, 0, 0, 1, 9, 0, 0);
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
